// File: rtl/sync_fifo_levels.sv
// Single-clock FIFO with fill-level reporting, almost-full threshold, sticky
// overflow/underflow flags and a selectable hold-last or show-ahead read port.
module sync_fifo_levels #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = DEPTH - 4,
  parameter int SHOW_AHEAD  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(ALMOST_FULL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_empty;
  logic             r_full;
  logic             r_almost_full;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_read_acc;
  logic             w_write_acc;
  logic             w_overflow_set;
  logic             w_underflow_set;
  logic [LW-1:0]    w_level_next;

  // A read is only accepted when data is present; a write into a full FIFO
  // is still accepted if a read frees the head slot on the same edge.
  assign w_read_acc      = read_en & ~r_empty;
  assign w_write_acc     = write_en & (~r_full | w_read_acc);
  assign w_overflow_set  = write_en & r_full & ~w_read_acc;
  assign w_underflow_set = read_en & r_empty;

  always_comb begin
    w_level_next = r_level;
    if (w_write_acc && !w_read_acc) begin
      w_level_next = r_level + LVL_ONE;
    end else if (w_read_acc && !w_write_acc) begin
      w_level_next = r_level - LVL_ONE;
    end else begin
      w_level_next = r_level;
    end
  end

  // Storage is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!reset && w_write_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_write_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_read_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Status flags derive from the next level so they never lag the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level       <= LVL_ZERO;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_level_next;
      r_empty       <= (w_level_next == LVL_ZERO);
      r_full        <= (w_level_next == LVL_FULL);
      r_almost_full <= (w_level_next >= LVL_AFULL);
    end
  end

  // Error setting wins over a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end else if (clear_flags) begin
        r_overflow <= 1'b0;
      end
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end else if (clear_flags) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (SHOW_AHEAD == 0) begin : g_hold_last
      logic [WIDTH-1:0] r_data_out;
      logic             r_data_valid;

      // Registered read port: holds the last popped word until the next pop.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_data_out   <= {WIDTH{1'b0}};
          r_data_valid <= 1'b0;
        end else if (w_read_acc) begin
          r_data_out   <= r_mem[r_rd_ptr];
          r_data_valid <= 1'b1;
        end else begin
          r_data_valid <= 1'b0;
        end
      end

      assign data_out   = r_data_out;
      assign data_valid = r_data_valid;
    end else begin : g_show_ahead
      // Head word is presented straight from storage; undefined while empty.
      assign data_out   = r_mem[r_rd_ptr];
      assign data_valid = ~r_empty;
    end
  endgenerate

  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_fifo_levels.sv
// Bench for sync_fifo_levels: a hold-last and a show-ahead instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_levels;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AF = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         write_en;
  logic         read_en;
  logic         clear_flags;
  logic [W-1:0] data_in;

  logic [W-1:0] dout0, dout1;
  logic         dv0, dv1, emp0, emp1, ful0, ful1, af0, af1, ovf0, ovf1, unf0, unf1;
  logic [2:0]   lvl0, lvl1;

  logic [W-1:0] q[$];
  logic         m_ovf, m_unf, m_dv;
  logic [W-1:0] m_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_levels #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(AF), .SHOW_AHEAD(0)) u_dut0 (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(dout0), .data_valid(dv0), .empty(emp0),
    .full(ful0), .almost_full(af0), .level(lvl0), .overflow(ovf0),
    .underflow(unf0), .clear_flags(clear_flags)
  );

  sync_fifo_levels #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(AF), .SHOW_AHEAD(1)) u_dut1 (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(dout1), .data_valid(dv1), .empty(emp1),
    .full(ful1), .almost_full(af1), .level(lvl1), .overflow(ovf1),
    .underflow(unf1), .clear_flags(clear_flags)
  );

  // One clock of stimulus; the reference model advances on the same edge.
  task automatic cyc(input logic we, input logic [W-1:0] d, input logic re,
                     input logic clr, input logic rst);
    int sz;
    logic racc, wacc;
    write_en = we; data_in = d; read_en = re; clear_flags = clr; reset = rst;
    @(posedge clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_dv = 1'b0;
    end else begin
      racc = re && (sz > 0);
      wacc = we && ((sz < D) || racc);
      if (racc) begin
        m_dout = q.pop_front();
        m_dv = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (wacc) q.push_back(d);
      if (we && (sz == D) && !racc) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (re && (sz == 0)) m_unf = 1'b1;
      else if (clr) m_unf = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (lvl0 !== 3'd0 || lvl1 !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d/%0d want 0", lvl0, lvl1); end
    n_vec++; if ({emp0, ful0, af0, emp1, ful1, af1} !== 6'b100_100) begin n_err++; $display("FAIL reset_status: got %b%b%b%b%b%b want 100100", emp0, ful0, af0, emp1, ful1, af1); end
    n_vec++; if ({ovf0, unf0, ovf1, unf1} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b%b%b%b want 0000", ovf0, unf0, ovf1, unf1); end
    n_vec++; if (dout0 !== 32'h0 || dv0 !== 1'b0 || dv1 !== 1'b0) begin n_err++; $display("FAIL reset_dout: got %h dv %b/%b want 0 dv 0/0", dout0, dv0, dv1); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_last();
    cyc(1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
    n_vec++; if (emp0 !== 1'b0 || lvl0 !== 3'd1) begin n_err++; $display("FAIL hold_write: got empty %b level %0d want 0/1", emp0, lvl0); end
    n_vec++; if (dout0 !== 32'h0 || dv0 !== 1'b0) begin n_err++; $display("FAIL hold_no_read: got %h dv %b want 0 dv 0", dout0, dv0); end
    n_vec++; if (dv1 !== 1'b1 || dout1 !== 32'hAABBCCDD) begin n_err++; $display("FAIL sa_first: got %h dv %b want aabbccdd dv 1", dout1, dv1); end
    idle(10);
    n_vec++; if (dout0 !== 32'h0 || lvl0 !== 3'd1) begin n_err++; $display("FAIL hold_idle: got %h level %0d want 0/1", dout0, lvl0); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (dout0 !== 32'hAABBCCDD || dv0 !== 1'b1) begin n_err++; $display("FAIL hold_read: got %h dv %b want aabbccdd dv 1", dout0, dv0); end
    n_vec++; if (emp0 !== 1'b1 || dv1 !== 1'b0) begin n_err++; $display("FAIL hold_drained: got empty %b sa_dv %b want 1/0", emp0, dv1); end
    idle(1);
    n_vec++; if (dv0 !== 1'b0) begin n_err++; $display("FAIL hold_pulse: got dv %b want 0", dv0); end
    idle(19);
    n_vec++; if (dout0 !== 32'hAABBCCDD || emp0 !== 1'b1) begin n_err++; $display("FAIL hold_keep: got %h empty %b want aabbccdd/1", dout0, emp0); end
  endtask

  task automatic test_fill_overflow();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
      n_vec++; if (lvl0 !== 3'(k) || af0 !== (k >= 3) || ful0 !== (k == 4)) begin n_err++; $display("FAIL fill_%0d: got level %0d af %b full %b", k, lvl0, af0, ful0); end
    end
    cyc(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    n_vec++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || lvl0 !== 3'd4) begin n_err++; $display("FAIL overflow: got ovf %b/%b level %0d want 1/1/4", ovf0, ovf1, lvl0); end
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (dout0 !== 32'(k) || dv0 !== 1'b1) begin n_err++; $display("FAIL drain_%0d: got %h dv %b want %h", k, dout0, dv0, 32'(k)); end
    end
    n_vec++; if (emp0 !== 1'b1 || ovf0 !== 1'b1) begin n_err++; $display("FAIL drain_empty: got empty %b ovf %b want 1/1", emp0, ovf0); end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b/%b want 0/0", ovf0, ovf1); end
  endtask

  task automatic test_wraparound();
    cyc(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 3; k <= 12; k++) begin
      cyc(1'b1, 32'(k), 1'b1, 1'b0, 1'b0);
      n_vec++; if (lvl0 !== 3'd2 || dout0 !== 32'(k - 2) || dv0 !== 1'b1) begin n_err++; $display("FAIL wrap_%0d: got level %0d dout %h want 2/%h", k, lvl0, dout0, 32'(k - 2)); end
      n_vec++; if (dout1 !== 32'(k - 1)) begin n_err++; $display("FAIL wrap_sa_%0d: got %h want %h", k, dout1, 32'(k - 1)); end
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (dout0 !== 32'd12 || emp0 !== 1'b1) begin n_err++; $display("FAIL wrap_tail: got %h empty %b want 0000000c/1", dout0, emp0); end
  endtask

  task automatic test_full_rw();
    for (int k = 1; k <= 4; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    n_vec++; if (ful0 !== 1'b1 || ovf0 !== 1'b0 || lvl0 !== 3'd4 || dout0 !== 32'd1) begin n_err++; $display("FAIL full_rw: got full %b ovf %b level %0d dout %h want 1/0/4/1", ful0, ovf0, lvl0, dout0); end
    for (int k = 2; k <= 5; k++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (dout0 !== ((k == 5) ? 32'h55 : 32'(k))) begin n_err++; $display("FAIL full_rw_drain_%0d: got %h", k, dout0); end
    end
    n_vec++; if (emp0 !== 1'b1 || ovf0 !== 1'b0) begin n_err++; $display("FAIL full_rw_end: got empty %b ovf %b want 1/0", emp0, ovf0); end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (unf0 !== 1'b1 || unf1 !== 1'b1 || lvl0 !== 3'd0) begin n_err++; $display("FAIL underflow: got %b/%b level %0d want 1/1/0", unf0, unf1, lvl0); end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (unf0 !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b want 0", unf0); end
    cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    n_vec++; if (lvl0 !== 3'd1 || unf0 !== 1'b1 || dv0 !== 1'b0) begin n_err++; $display("FAIL empty_rw: got level %0d unf %b dv %b want 1/1/0", lvl0, unf0, dv0); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_vec++; if (unf0 !== 1'b1 || dout0 !== 32'h77) begin n_err++; $display("FAIL unf_set_wins: got unf %b dout %h want 1/77", unf0, dout0); end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_show_ahead();
    cyc(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b0);
    n_vec++; if (dv1 !== 1'b1 || dout1 !== 32'hDDCCBBAA) begin n_err++; $display("FAIL sa_write: got %h dv %b want ddccbbaa dv 1", dout1, dv1); end
    cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    n_vec++; if (dout1 !== 32'h11 || lvl1 !== 3'd2) begin n_err++; $display("FAIL sa_advance: got %h level %0d want 11/2", dout1, lvl1); end
    cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
    n_vec++; if (lvl1 !== 3'd0 || emp1 !== 1'b1 || dv1 !== 1'b0 || {ovf1, unf1} !== 2'b00) begin n_err++; $display("FAIL sa_reset: got level %0d empty %b dv %b flags %b%b", lvl1, emp1, dv1, ovf1, unf1); end
    cyc(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
    n_vec++; if (dout1 !== 32'h1234 || lvl1 !== 3'd1) begin n_err++; $display("FAIL sa_after_reset: got %h level %0d want 1234/1", dout1, lvl1); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (emp1 !== 1'b1 || dout0 !== 32'h1234) begin n_err++; $display("FAIL sa_only_new: got empty %b hold %h want 1/1234", emp1, dout0); end
  endtask

  task automatic test_random();
    logic [W-1:0] head;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 5), ($urandom_range(0, 199) < 2));
      n_vec++;
      if (lvl0 !== 3'(q.size()) || lvl1 !== 3'(q.size()) || emp0 !== (q.size() == 0) ||
          ful0 !== (q.size() == D) || af0 !== (q.size() >= AF) || emp1 !== emp0 ||
          ful1 !== ful0 || af1 !== af0) begin
        n_err++; $display("FAIL rnd_status_%0d: got level %0d/%0d e%b f%b af%b want level %0d", i, lvl0, lvl1, emp0, ful0, af0, q.size());
      end
      n_vec++;
      if (ovf0 !== m_ovf || unf0 !== m_unf || ovf1 !== m_ovf || unf1 !== m_unf) begin
        n_err++; $display("FAIL rnd_flags_%0d: got ovf %b unf %b want %b %b", i, ovf0, unf0, m_ovf, m_unf);
      end
      n_vec++;
      if (dout0 !== m_dout || dv0 !== m_dv || dv1 !== (q.size() > 0)) begin
        n_err++; $display("FAIL rnd_dout_%0d: got %h dv %b sa_dv %b want %h dv %b", i, dout0, dv0, dv1, m_dout, m_dv);
      end
      if (q.size() > 0) begin
        head = q[0];
        n_vec++;
        if (dout1 !== head) begin
          n_err++; $display("FAIL rnd_sa_head_%0d: got %h want %h", i, dout1, head);
        end
      end
    end
  endtask

  initial begin
    write_en = 1'b0; read_en = 1'b0; clear_flags = 1'b0; reset = 1'b1; data_in = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_dout = '0;
    test_reset();
    test_hold_last();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    test_fill_overflow();
    test_wraparound();
    test_full_rw();
    test_underflow();
    test_show_ahead();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
